// File: rtl/btb_nway.sv
// N-way set-associative branch target buffer: registered lookup, round-robin
// replacement, multi-cycle flush sweep. Define BTB_PRED_EN for 2-bit direction counters.
module btb_nway #(
  parameter int WAYS = 2,
  parameter int SETS = 16,
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            lookup_valid,
  input  logic [XLEN-1:0] lookup_pc,
  output logic            rsp_valid,
  output logic            rsp_hit,
  output logic [XLEN-1:0] rsp_target,
  output logic            rsp_branch,
  output logic            rsp_jump,
  output logic            rsp_taken,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_branch,
  input  logic            upd_jump,
  input  logic            upd_taken,
  input  logic            flush,
  output logic            busy
);
  localparam int SET_BITS  = $clog2(SETS);
  localparam int TAG_WIDTH = XLEN - 2 - SET_BITS;
  localparam int RR_W      = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t                state;
  logic [SET_BITS-1:0]   set_cnt;
  logic [WAYS-1:0]       valid     [SETS];
  logic [WAYS-1:0]       jump_line [SETS];
  logic [RR_W-1:0]       rr_ptr    [SETS];
  logic [TAG_WIDTH-1:0]  tag       [SETS][WAYS];
  logic [XLEN-1:0]       target    [SETS][WAYS];
`ifdef BTB_PRED_EN
  logic [1:0]            cnt       [SETS][WAYS];
`endif

  logic [SET_BITS-1:0]  l_set, u_set;
  logic [TAG_WIDTH-1:0] l_tag, u_tag;
  assign l_set = lookup_pc[SET_BITS+1:2];
  assign l_tag = lookup_pc[XLEN-1:SET_BITS+2];
  assign u_set = upd_pc[SET_BITS+1:2];
  assign u_tag = upd_pc[XLEN-1:SET_BITS+2];

  logic unused;
  assign unused = ^{lookup_pc[1:0], upd_pc[1:0]};

  // Descending scans leave the lowest matching / invalid way selected.
  logic            l_hit, u_hit, u_has_inv;
  logic [RR_W-1:0] l_way, u_way, u_inv_way;
  always_comb begin
    l_hit = 1'b0;  l_way = '0;
    u_hit = 1'b0;  u_way = '0;
    u_has_inv = 1'b0;  u_inv_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid[l_set][w] && tag[l_set][w] == l_tag) begin
        l_hit = 1'b1;
        l_way = RR_W'(w);
      end
      if (valid[u_set][w] && tag[u_set][w] == u_tag) begin
        u_hit = 1'b1;
        u_way = RR_W'(w);
      end
      if (!valid[u_set][w]) begin
        u_has_inv = 1'b1;
        u_inv_way = RR_W'(w);
      end
    end
  end

  logic            u_is_jump, u_is_br, l_taken;
  logic [RR_W-1:0] victim;
  assign u_is_jump = upd_jump;
  assign u_is_br   = upd_branch && !upd_jump;
  assign victim    = u_has_inv ? u_inv_way : rr_ptr[u_set];
`ifdef BTB_PRED_EN
  assign l_taken = jump_line[l_set][l_way] || cnt[l_set][l_way][1];
`else
  assign l_taken = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid  <= 1'b0;
      rsp_hit    <= 1'b0;
      rsp_target <= '0;
      rsp_branch <= 1'b0;
      rsp_jump   <= 1'b0;
      rsp_taken  <= 1'b0;
    end else begin
      rsp_valid <= lookup_valid;
      if (lookup_valid && state == IDLE && l_hit) begin
        rsp_hit    <= 1'b1;
        rsp_target <= target[l_set][l_way];
        rsp_branch <= !jump_line[l_set][l_way];
        rsp_jump   <= jump_line[l_set][l_way];
        rsp_taken  <= l_taken;
      end else begin
        rsp_hit    <= 1'b0;
        rsp_target <= '0;
        rsp_branch <= 1'b0;
        rsp_jump   <= 1'b0;
        rsp_taken  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      set_cnt <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid[s]  <= '0;
        rr_ptr[s] <= '0;
`ifdef BTB_PRED_EN
        for (int w = 0; w < WAYS; w++) cnt[s][w] <= 2'b00;
`endif
      end
    end else begin
      case (state)
        IDLE: begin
          if (flush) begin
            valid[0]  <= '0;
            rr_ptr[0] <= '0;
`ifdef BTB_PRED_EN
            for (int w = 0; w < WAYS; w++) cnt[0][w] <= 2'b00;
`endif
            set_cnt <= SET_BITS'(1);
            state   <= FLUSH;
            busy    <= 1'b1;
          end else if (upd_valid && (u_is_jump || u_is_br)) begin
            if (u_hit) begin
              target[u_set][u_way]    <= upd_target;
              jump_line[u_set][u_way] <= u_is_jump;
`ifdef BTB_PRED_EN
              if (u_is_br) begin
                if (upd_taken && cnt[u_set][u_way] != 2'b11)
                  cnt[u_set][u_way] <= cnt[u_set][u_way] + 2'b01;
                else if (!upd_taken && cnt[u_set][u_way] != 2'b00)
                  cnt[u_set][u_way] <= cnt[u_set][u_way] - 2'b01;
              end
`endif
            end else if (u_is_jump || upd_taken) begin
              valid[u_set][victim]     <= 1'b1;
              tag[u_set][victim]       <= u_tag;
              target[u_set][victim]    <= upd_target;
              jump_line[u_set][victim] <= u_is_jump;
`ifdef BTB_PRED_EN
              cnt[u_set][victim] <= 2'b10;
`endif
              if (!u_has_inv)
                rr_ptr[u_set] <= (WAYS == 1) ? '0 : rr_ptr[u_set] + 1'b1;
            end
          end
        end
        FLUSH: begin
          valid[set_cnt]  <= '0;
          rr_ptr[set_cnt] <= '0;
`ifdef BTB_PRED_EN
          for (int w = 0; w < WAYS; w++) cnt[set_cnt][w] <= 2'b00;
`endif
          set_cnt <= set_cnt + 1'b1;
          if (set_cnt == SET_BITS'(SETS - 1)) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_btb_nway.sv
// Directed table-driven bench for btb_nway (WAYS=2, SETS=16) plus a flush sequence.
module tb_btb_nway;
  logic        clk = 1'b0;
  logic        rst;
  logic        lookup_valid;
  logic [31:0] lookup_pc;
  logic        rsp_valid, rsp_hit, rsp_branch, rsp_jump, rsp_taken;
  logic [31:0] rsp_target;
  logic        upd_valid;
  logic [31:0] upd_pc, upd_target;
  logic        upd_branch, upd_jump, upd_taken;
  logic        flush, busy;

`ifdef BTB_PRED_EN
  localparam bit PRED = 1'b1;
`else
  localparam bit PRED = 1'b0;
`endif

  btb_nway #(.WAYS(2), .SETS(16), .XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
    .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_target(rsp_target),
    .rsp_branch(rsp_branch), .rsp_jump(rsp_jump), .rsp_taken(rsp_taken),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target),
    .upd_branch(upd_branch), .upd_jump(upd_jump), .upd_taken(upd_taken),
    .flush(flush), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, lv, uv, ub, uj, ut;
    logic [31:0] lpc, upc, utgt;
    logic        ev, eh, eb, ej, et;
    logic [31:0] etgt;
  } vec_t;

  vec_t vecs[$];
  int   passed = 0, total = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  function automatic vec_t vnone();
    vec_t v;
    v = '{default: '0};
    return v;
  endfunction

  function automatic vec_t vrst();
    vec_t v = vnone();
    v.rst = 1'b1;
    return v;
  endfunction

  function automatic vec_t vup(input logic [31:0] pc, tgt, input logic b, j, t);
    vec_t v = vnone();
    v.uv = 1'b1; v.upc = pc; v.utgt = tgt; v.ub = b; v.uj = j; v.ut = t;
    return v;
  endfunction

  // Lookup with expected response; miss expects all-zero payload.
  function automatic vec_t vlk(input logic [31:0] pc, input logic h,
                               input logic [31:0] tgt, input logic b, j, t);
    vec_t v = vnone();
    v.lv = 1'b1; v.lpc = pc;
    v.ev = 1'b1; v.eh = h; v.etgt = tgt; v.eb = b; v.ej = j; v.et = t;
    return v;
  endfunction

  task automatic drive_idle();
    rst = 1'b0; lookup_valid = 1'b0; lookup_pc = '0; upd_valid = 1'b0;
    upd_pc = '0; upd_target = '0; upd_branch = 1'b0; upd_jump = 1'b0;
    upd_taken = 1'b0; flush = 1'b0;
  endtask

  function automatic logic [63:0] outs();
    return {26'd0, rsp_valid, rsp_hit, rsp_branch, rsp_jump, rsp_taken, busy, rsp_target};
  endfunction

  initial begin
    vec_t v;
    logic [31:0] pcs [4];
    int bcnt, n;

    vecs.push_back(vnone());                                    // reset state
    vecs.push_back(vlk(32'h40, 0, 0, 0, 0, 0));                 // cold miss
    vecs.push_back(vup(32'h40, 32'h100, 0, 1, 0));              // jump alloc
    vecs.push_back(vnone());
    vecs.push_back(vlk(32'h40, 1, 32'h100, 0, 1, 1));
    vecs.push_back(vrst());
    vecs.push_back(vup(32'h40, 32'h400, 1, 0, 1));              // set 0 way 0
    vecs.push_back(vup(32'h80, 32'h800, 1, 0, 1));              // set 0 way 1
    vecs.push_back(vup(32'hC0, 32'hC00, 1, 0, 1));              // evicts 0x40, rr -> 1
    vecs.push_back(vlk(32'h40, 0, 0, 0, 0, 0));
    vecs.push_back(vlk(32'h80, 1, 32'h800, 1, 0, 1));
    vecs.push_back(vlk(32'hC0, 1, 32'hC00, 1, 0, 1));
    vecs.push_back(vup(32'h100, 32'h1000, 1, 0, 1));            // evicts 0x80, rr -> 0
    vecs.push_back(vlk(32'h80, 0, 0, 0, 0, 0));
    vecs.push_back(vlk(32'h100, 1, 32'h1000, 1, 0, 1));
    vecs.push_back(vup(32'h44, 32'h444, 1, 0, 0));              // not-taken miss: no alloc
    vecs.push_back(vlk(32'h44, 0, 0, 0, 0, 0));
    v = vlk(32'h100, 1, 32'h1000, 1, 0, 1);                     // read-before-write
    v.uv = 1'b1; v.upc = 32'h100; v.utgt = 32'h2000; v.ub = 1'b1; v.ut = 1'b1;
    vecs.push_back(v);
    vecs.push_back(vlk(32'h100, 1, 32'h2000, 1, 0, 1));
    vecs.push_back(vup(32'hC0, 32'h3C0, 1, 1, 0));              // jump wins over branch
    vecs.push_back(vlk(32'hC0, 1, 32'h3C0, 0, 1, 1));
    vecs.push_back(vup(32'h48, 32'h48, 0, 0, 1));               // neither type: ignored
    vecs.push_back(vlk(32'h48, 0, 0, 0, 0, 0));
    vecs.push_back(vup(32'h50, 32'h500, 1, 0, 1));              // set 4, counter 2'b10
    vecs.push_back(vup(32'h50, 32'h500, 1, 0, 0));
    vecs.push_back(vup(32'h50, 32'h500, 1, 0, 0));
    vecs.push_back(vlk(32'h50, 1, 32'h500, 1, 0, !PRED));
    vecs.push_back(vup(32'h50, 32'h500, 1, 0, 1));
    vecs.push_back(vup(32'h50, 32'h500, 1, 0, 1));
    vecs.push_back(vlk(32'h50, 1, 32'h500, 1, 0, 1));

    drive_idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    foreach (vecs[i]) begin
      rst = vecs[i].rst; lookup_valid = vecs[i].lv; lookup_pc = vecs[i].lpc;
      upd_valid = vecs[i].uv; upd_pc = vecs[i].upc; upd_target = vecs[i].utgt;
      upd_branch = vecs[i].ub; upd_jump = vecs[i].uj; upd_taken = vecs[i].ut;
      flush = 1'b0;
      @(posedge clk); #1;
      chk($sformatf("vec%0d", i), outs(),
          {26'd0, vecs[i].ev, vecs[i].eh, vecs[i].eb, vecs[i].ej, vecs[i].et, 1'b0, vecs[i].etgt});
    end

    // Flush sweep: busy for 15 cycles, updates dropped, re-pulse ignored.
    drive_idle();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_busy_start", {63'd0, busy}, 64'd1);
    bcnt = 1; n = 0;
    while (busy && n < 40) begin
      lookup_valid = 1'b1; lookup_pc = 32'h100;
      upd_valid = (n == 0); upd_pc = 32'h60; upd_target = 32'h600; upd_jump = 1'b1;
      flush = (n == 3);
      @(posedge clk); #1;
      n++;
      chk("flush_lookup", {62'd0, rsp_valid, rsp_hit}, 64'd2);
      if (busy) bcnt++;
    end
    chk("flush_busy_len", 64'(bcnt), 64'd15);

    drive_idle();
    pcs = '{32'hC0, 32'h100, 32'h50, 32'h60};
    for (int i = 0; i < 4; i++) begin
      lookup_valid = 1'b1; lookup_pc = pcs[i];
      @(posedge clk); #1;
      chk($sformatf("post_flush_miss%0d", i), outs(), {26'd0, 6'b100000, 32'd0});
    end
    drive_idle();
    upd_valid = 1'b1; upd_pc = 32'h60; upd_target = 32'h600; upd_jump = 1'b1;
    @(posedge clk); #1;
    drive_idle();
    lookup_valid = 1'b1; lookup_pc = 32'h60;
    @(posedge clk); #1;
    chk("post_flush_alloc", outs(), {26'd0, 6'b110110, 32'h600});
    drive_idle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
